// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the unified-memory port arbiter.
package mem_arb_pkg;
  localparam logic [0:0] LG_FETCH = 1'b0;
  localparam logic [0:0] LG_DATA = 1'b1;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  function automatic logic misaligned(input logic half, input logic is_byte, input logic [1:0] a);
    return is_byte ? 1'b0 : half ? a[0] : |a;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_load_extend.sv
// load_extend: sign/zero extension of memory read data by access size.
module load_extend (
  input  logic [31:0] i_data,
  input  logic        i_half,
  input  logic        i_byte,
  input  logic        i_signed,
  output logic [31:0] o_data
);
  assign o_data = i_byte ? {{24{i_signed & i_data[7]}}, i_data[7:0]} :
                  i_half ? {{16{i_signed & i_data[15]}}, i_data[15:0]} : i_data;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the single memory port between fetch and data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_instr,
  input  logic             d_req,
  input  logic             d_we,
  input  logic             d_re,
  input  logic             d_half,
  input  logic             d_byte,
  input  logic             d_signed,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_err,
  output logic [31:0]      mem_addr,
  output logic             mem_tick_tock,
  output logic             mem_write,
  output logic             mem_read,
  output logic             mem_half,
  output logic             mem_byte,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);
  logic [0:0]       r_last_gnt;
  logic             r_if_rvalid, r_d_rvalid, r_d_err;
  logic [31:0]      r_if_instr, r_d_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic             w_if_gnt, w_d_gnt, w_d_ill, w_if_ill, w_d_ok;
  logic [31:0]      w_ext;
  // grants are gated by rst_n so nothing reaches memory while reset is held
  assign w_if_gnt = rst_n & if_req & (~d_req | (r_last_gnt == LG_DATA));
  assign w_d_gnt = rst_n & d_req & ~w_if_gnt;
  assign w_d_ill = (d_we & d_re) | ~(d_we | d_re) | (d_half & d_byte) |
                   misaligned(d_half, d_byte, d_addr[1:0]) | (|d_addr[31:ADDR_W]);
  assign w_if_ill = (|if_addr[1:0]) | (|if_addr[31:ADDR_W]);
  assign w_d_ok = w_d_gnt & ~w_d_ill;
  assign if_gnt = w_if_gnt;
  assign d_gnt = w_d_gnt;
  assign mem_tick_tock = ~w_if_gnt;
  assign mem_addr = w_if_gnt ? if_addr : w_d_gnt ? d_addr : '0;
  assign mem_write = w_d_ok & d_we;
  assign mem_read = w_d_ok & d_re;
  assign mem_half = w_d_gnt & d_half;
  assign mem_byte = w_d_gnt & d_byte;
  assign mem_wdata = w_d_gnt ? d_wdata : '0;
  load_extend u_ext (
    .i_data(mem_rdata),
    .i_half(d_half),
    .i_byte(d_byte),
    .i_signed(d_signed),
    .o_data(w_ext)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= LG_DATA;
      r_if_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_d_err <= 1'b0;
      r_if_instr <= '0;
      r_d_rdata <= '0;
      r_cnt <= '0;
    end else begin
      r_last_gnt <= w_if_gnt ? LG_FETCH : w_d_gnt ? LG_DATA : r_last_gnt;
      r_if_rvalid <= w_if_gnt;
      r_d_rvalid <= w_d_gnt;
      r_d_err <= w_d_gnt & w_d_ill;
      if (w_if_gnt) r_if_instr <= w_if_ill ? NOP_INSTR : mem_rdata;
      if (w_d_gnt) r_d_rdata <= (w_d_ill | d_we) ? '0 : w_ext;
      if (if_req & d_req & ~&r_cnt) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign if_rvalid = r_if_rvalid;
  assign if_instr = r_if_instr;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata = r_d_rdata;
  assign d_err = r_d_err;
  assign conflict_cnt = r_cnt;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single-ported unified `Memory`. It shares the port between the fetch stage and the MEM stage and drives `tick_tock`: 0 for an instruction fetch, 1 for a data load/store. Read data comes back through one-cycle registered responses, with sign extension applied for loads. The block sits between the pipeline front/back ends and `Memory`, and its grant outputs feed the hazard unit as stall sources.

## Interface

- `ADDR_W`, default 8: implemented byte-address bits (256-byte memory).
- `CNT_W`, default 16: width of the conflict counter.

Ports:

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1, `if_addr` in 32: fetch request and its byte address.
- `if_gnt` out 1: combinational, fetch request accepted this cycle.
- `if_rvalid` out 1, `if_instr` out 32: registered fetch response.
- `d_req` in 1: data request.
- `d_we` in 1, `d_re` in 1: store and load selects.
- `d_half` in 1, `d_byte` in 1: halfword and byte size selects.
- `d_signed` in 1: sign-extend the load result.
- `d_addr` in 32, `d_wdata` in 32: data address and store data.
- `d_gnt` out 1: combinational, data request accepted this cycle.
- `d_rvalid` out 1, `d_rdata` out 32: registered data response.
- `d_err` out 1: registered error pulse, aligned with `d_rvalid` timing.
- `mem_addr` out 32, `mem_tick_tock` out 1: memory address and phase select.
- `mem_write` out 1, `mem_read` out 1: memory write and read strobes.
- `mem_half` out 1, `mem_byte` out 1, `mem_wdata` out 32: memory size selects and store data.
- `mem_rdata` in 32: memory read data.
- `conflict_cnt` out `CNT_W`: saturating count of cycles with both requests high.

## Operation

- **State** (the FSM): 1-bit `last_gnt` register, values `LG_FETCH` and `LG_DATA`.
  - Reset value is `LG_DATA`, so fetch wins the first conflict.
- **Grant, computed combinationally each cycle:**
  - Only one request high: grant it.
  - Both requests high: grant the side opposite `last_gnt` (round robin).
  - `last_gnt` updates on any grant.
- **Fetch grant drives:**
  - `mem_tick_tock=0`, `mem_addr=if_addr`.
  - `mem_write=0`, `mem_read=0`, `mem_half=0`, `mem_byte=0`.
- **Data grant drives:**
  - `mem_tick_tock=1`, `mem_addr=d_addr`.
  - `mem_write=d_we`, `mem_read=d_re`, `mem_half=d_half`, `mem_byte=d_byte`, `mem_wdata=d_wdata`.
- **No grant (idle):**
  - `mem_tick_tock=1`, all strobes 0, `mem_addr=0`.
- **Illegal data request.** The request is still granted and `d_err` pulses in the response cycle. Memory strobes are forced to 0. A request is illegal if any of these hold:
  - `d_we & d_re` both high;
  - neither `d_we` nor `d_re` is high;
  - `d_half & d_byte` both high;
  - word access with `d_addr[1:0]!=0`;
  - halfword access with `d_addr[0]!=0`;
  - `d_addr[31:ADDR_W]!=0`.
- **Illegal fetch.** A fetch is illegal if `if_addr[1:0]!=0` or it is out of range. It is granted; `if_rvalid` pulses with `if_instr=32'h00000013` (NOP), and the memory is not read.
- **Load extension**, applied to `mem_rdata` before registering:
  - byte: `d_signed` replicates bit 7 into [31:8];
  - half: `d_signed` replicates bit 15 into [31:16];
  - word: passed through unchanged.
- **Store response:**
  - `d_rvalid=1`, `d_rdata=0`.
- **`conflict_cnt`:**
  - increments on every cycle with `if_req & d_req`;
  - saturates at all-ones.

## Timing

- Requesters hold the request and every field stable until the matching grant is seen high at a rising edge.
- Grant is combinational, so requests must not depend combinationally on grant.
- Response latency:
  - The grant cycle is N.
  - `*_rvalid` is high for exactly cycle N+1, with data captured at the edge ending N.
  - A store commits in `Memory` at that same edge.
- A new request may be presented in cycle N+1; back-to-back grants on one side give one response per cycle.
- Maximum wait under continuous contention is one cycle per side.
- A response register holds its last data when `rvalid=0`.
- Reset values, while `rst_n=0` (async, immediate):
  - `if_rvalid=0`, `d_rvalid=0`, `d_err=0`;
  - `if_instr=0`, `d_rdata=0`;
  - `conflict_cnt=0`, `last_gnt=LG_DATA`.
- Reset in the middle of an operation:
  - A response pending at reset assertion is dropped.
  - Grants are suppressed (outputs 0) while `rst_n=0`.
  - No store reaches memory, because the memory strobes are gated by grant.

## Structure

- Shared package `mem_arb_pkg`: the `LG_FETCH`/`LG_DATA` encodings and `NOP_INSTR = 32'h00000013`.
- Size encodings stay the existing `HalfOperation`/`ByteOperation` flags.
- One natural sub-module, `load_extend`: combinational sign/zero extension by size and `d_signed`.
- The grant logic, legality checks, response registers and counter live in the top module.

## Test plan

The bench connects the block to `Memory`, preloaded with bytes 0..3 = FF,54,01,02.

- **Lone fetch:** `if_req=1`, `if_addr=0` -> `if_gnt=1`, `mem_tick_tock=0`; next cycle `if_rvalid=1`, `if_instr=32'h020154FF`.
- **Loads from address 0:**
  - byte, `d_signed=1` -> `d_rdata=32'hFFFFFFFF`;
  - byte, `d_signed=0` -> `32'h000000FF`;
  - half, `d_signed=1` -> `32'h000054FF`.
- **Contention:** `if_req` and `d_req` held high for 4 cycles after reset.
  - Grants go fetch, data, fetch, data.
  - `conflict_cnt=4`, and each side gets 2 responses.
- **Store then load:** word store of `32'hDEADBEEF` to address 8, then word load from 8 -> `d_rdata=32'hDEADBEEF` one cycle after the load grant.
- **Errors:**
  - Word load at address 2 -> `d_err=1`, `mem_read=0` during the grant cycle.
  - Fetch at address 32'h100 -> `if_instr=32'h00000013`.
- **Reset mid-operation:**
  - Assert `rst_n=0` in a data grant cycle -> `d_rvalid` stays 0, memory unchanged.
  - After release, the first conflict is granted to fetch.
